// File: rtl/fsm_test_pkg.sv
// Shared types for the sequence-FSM fault tester: tester states, 2-bit {s,t} state
// and the golden next-state function of the FSM under test.
package fsm_test_pkg;
    localparam int MAX_SEQ_LEN = 32;
    localparam int IDX_W       = 5;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, CHECK, DONE} tester_state_t;
    typedef logic [1:0] st_t;

    function automatic st_t golden_next(st_t cur, logic a);
        logic s, t;
        st_t  n;
        s    = cur[1];
        t    = cur[0];
        n[1] = (~s & t) | (s & a & ~t);
        n[0] = (a & ~s & ~t) | (~a & ~s & t);
        return n;
    endfunction
endpackage

// File: rtl/fsm_fault_tester_if.sv
// Signals between the test controller / DUT state register and the fault tester.
// slave = the tester; master = the environment driving start and the DUT state bits.
interface fsm_fault_tester_if;
    import fsm_test_pkg::*;

    logic             start;
    logic             a_out;
    logic             dut_clr;
    logic             s_in;
    logic             t_in;
    logic             busy;
    logic             done;
    logic             fault;
    logic [IDX_W-1:0] fault_index;
    st_t              exp_state;
    st_t              obs_state;

    modport master (
        output start, s_in, t_in,
        input  a_out, dut_clr, busy, done, fault, fault_index, exp_state, obs_state
    );
    modport slave (
        input  start, s_in, t_in,
        output a_out, dut_clr, busy, done, fault, fault_index, exp_state, obs_state
    );
endinterface

// File: rtl/fsm_fault_tester_golden_fsm.sv
// Golden copy of the (s,t) sequence FSM; advances only while enabled, so it steps
// on exactly the same edges as the DUT during a run.
module golden_fsm
    import fsm_test_pkg::*;
(
    input  logic Clock,
    input  logic nReset,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_a,
    output st_t  o_state
);
    st_t r_state;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            r_state <= '0;
        else if (i_clr)
            r_state <= '0;
        else if (i_en)
            r_state <= golden_next(r_state, i_a);
    end

    assign o_state = r_state;
endmodule

// File: rtl/fsm_fault_tester.sv
// Applies SEQ to the DUT's a input one bit per cycle and compares the DUT state
// against the golden model, latching the first mismatch.
module fsm_fault_tester
    import fsm_test_pkg::*;
#(
    parameter int                     SEQ_LEN = 16,
    parameter logic [MAX_SEQ_LEN-1:0] SEQ     = 32'h0000_B4E1
) (
    input logic               Clock,
    input logic               nReset,
    fsm_fault_tester_if.slave bus
);
    if (SEQ_LEN < 2 || SEQ_LEN > MAX_SEQ_LEN) begin : g_seq_len_check
        $error("fsm_fault_tester: SEQ_LEN must be within 2..32");
    end

    localparam logic [IDX_W-1:0] LAST = IDX_W'(SEQ_LEN - 1);

    tester_state_t    r_state;
    logic [IDX_W-1:0] r_k;
    logic             r_a;
    logic             r_clr;
    logic             r_busy;
    logic             r_done;
    logic             r_fault;
    logic [IDX_W-1:0] r_idx;
    st_t              r_exp;
    st_t              r_obs;

    st_t  w_golden;
    st_t  w_obs;
    logic w_mismatch;

    assign w_obs      = {bus.s_in, bus.t_in};
    assign w_mismatch = (w_obs != w_golden);

    golden_fsm u_golden (
        .Clock   (Clock),
        .nReset  (nReset),
        .i_clr   (r_state == CLEAR),
        .i_en    (r_state == RUN),
        .i_a     (r_a),
        .o_state (w_golden)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_a     <= 1'b0;
            r_clr   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_idx   <= '0;
            r_exp   <= '0;
            r_obs   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state <= CLEAR;
                        r_clr   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_fault <= 1'b0;
                        r_idx   <= '0;
                        r_exp   <= '0;
                        r_obs   <= '0;
                    end
                end
                CLEAR: begin
                    r_state <= RUN;
                    r_clr   <= 1'b0;
                    r_k     <= '0;
                    r_a     <= SEQ[0];
                end
                RUN: begin
                    // At k=0 the DUT is still settling out of the clear, so no compare.
                    if (r_k != '0 && w_mismatch) begin
                        r_state <= DONE;
                        r_a     <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_fault <= 1'b1;
                        r_idx   <= r_k - IDX_W'(1);
                        r_exp   <= w_golden;
                        r_obs   <= w_obs;
                    end else if (r_k == LAST) begin
                        r_state <= CHECK;
                        r_a     <= 1'b0;
                    end else begin
                        r_k <= r_k + IDX_W'(1);
                        r_a <= SEQ[r_k + IDX_W'(1)];
                    end
                end
                CHECK: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    if (w_mismatch) begin
                        r_fault <= 1'b1;
                        r_idx   <= LAST;
                        r_exp   <= w_golden;
                        r_obs   <= w_obs;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.a_out       = r_a;
    assign bus.dut_clr     = r_clr;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.fault       = r_fault;
    assign bus.fault_index = r_idx;
    assign bus.exp_state   = r_exp;
    assign bus.obs_state   = r_obs;
endmodule

// File: tb/tb_fsm_fault_tester.sv
// Bench: three testers (fault-free, f stuck-at-1, f stuck-at-0 DUT models) with a
// scoreboard queue of expected run results popped on each rising done.
module tb_fsm_fault_tester;
    logic Clock = 1'b0;
    logic nReset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    logic [2:0]      start_v;
    logic [2:0]      a_v, clr_v, busy_v, done_v, fault_v;
    logic [2:0][4:0] idx_v;
    logic [2:0][1:0] exp_v, obs_v;

    // DUT model: s+ = (~s & t) | ~f with f = NAND(s, a, ~t); mode 1 forces f=1, mode 2 forces f=0.
    function automatic logic [1:0] model_next(input logic [1:0] cur, input logic a, input int mode);
        logic s, t, f, term;
        s    = cur[1];
        t    = cur[0];
        f    = ~(s & a & ~t);
        term = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ~f;
        return {(~s & t) | term, (a & ~s & ~t) | (~a & ~s & t)};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam logic [31:0] GSEQ = (g == 0) ? 32'h0000_B4E1 : (g == 1) ? 32'h0000_0007 : 32'h0;
        logic [1:0] mst;
        fsm_fault_tester_if ifc ();
        fsm_fault_tester #(.SEQ_LEN(16), .SEQ(GSEQ)) u_dut (
            .Clock  (Clock),
            .nReset (nReset),
            .bus    (ifc)
        );
        always @(posedge Clock or negedge nReset) begin
            if (!nReset)         mst <= 2'b00;
            else if (ifc.dut_clr) mst <= 2'b00;
            else                  mst <= model_next(mst, ifc.a_out, g);
        end
        assign ifc.start  = start_v[g];
        assign ifc.s_in   = mst[1];
        assign ifc.t_in   = mst[0];
        assign a_v[g]     = ifc.a_out;
        assign clr_v[g]   = ifc.dut_clr;
        assign busy_v[g]  = ifc.busy;
        assign done_v[g]  = ifc.done;
        assign fault_v[g] = ifc.fault;
        assign idx_v[g]   = ifc.fault_index;
        assign exp_v[g]   = ifc.exp_state;
        assign obs_v[g]   = ifc.obs_state;
    end

    typedef struct {
        int         id;
        logic       fault;
        logic [4:0] idx;
        logic [1:0] exp_st;
        logic [1:0] obs_st;
        int         done_cyc;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [13:0] outs(input int i);
        return {a_v[i], clr_v[i], busy_v[i], done_v[i], fault_v[i], idx_v[i], exp_v[i], obs_v[i]};
    endfunction

    // Called at a negedge; returns at the negedge after start is sampled (CLEAR cycle).
    task automatic start_run(input int id, input bit push, input int hold, input int lat,
                             input logic f, input logic [4:0] idx, input logic [1:0] e, input logic [1:0] o);
        exp_t it;
        if (push) begin
            it.id = id; it.fault = f; it.idx = idx; it.exp_st = e; it.obs_st = o;
            it.done_cyc = cyc + 1 + lat;
            sbq.push_back(it);
        end
        start_v[id] = 1'b1;
        repeat (hold) @(negedge Clock);
        start_v[id] = 1'b0;
    endtask

    task automatic wait_done(input int id, input int budget);
        int n = 0;
        while (!done_v[id] && n < budget) begin
            @(negedge Clock);
            n++;
        end
        check($sformatf("done_within_budget%0d", id), 32'(done_v[id]), 1);
    endtask

    // Scoreboard monitor
    logic [2:0] prev_done = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            for (int i = 0; i < 3; i++) begin
                if (done_v[i] && !prev_done[i]) begin
                    if (sbq.size() == 0) begin
                        check($sformatf("sb_unexpected_done%0d", i), 32'(done_v[i]), 0);
                    end else begin
                        e = sbq.pop_front();
                        check("sb_id", 32'(i), 32'(e.id));
                        check($sformatf("sb_result%0d", i),
                              {fault_v[i], idx_v[i], exp_v[i], obs_v[i]},
                              {e.fault, e.idx, e.exp_st, e.obs_st});
                        check($sformatf("sb_latency%0d", i), 32'(cyc), 32'(e.done_cyc));
                    end
                end
            end
            prev_done = done_v;
        end
    end

    logic [31:0] seq0 = 32'h0000_B4E1;
    int          nbusy, nclr;
    logic        exp_a;

    initial begin
        nReset  = 1'b0;
        start_v = '0;
        repeat (3) @(negedge Clock);
        for (int i = 0; i < 3; i++) check($sformatf("reset_outs%0d", i), 32'(outs(i)), 0);
        nReset = 1'b1;
        @(negedge Clock);
        check("idle_a_out", 32'(a_v[0]), 0);

        // Fault-free run with per-cycle a_out, busy and dut_clr tracking
        start_run(0, 1'b1, 1, 18, 1'b0, 5'd0, 2'b00, 2'b00);
        nbusy = 0;
        nclr  = 0;
        for (int j = 0; j < 18; j++) begin
            if (busy_v[0]) nbusy++;
            if (clr_v[0])  nclr++;
            exp_a = (j >= 1 && j <= 16) ? seq0[j-1] : 1'b0;
            check($sformatf("a_out_cycle%0d", j), 32'(a_v[0]), 32'(exp_a));
            @(negedge Clock);
        end
        check("busy_cycles", 32'(nbusy), 18);
        check("dut_clr_cycles", 32'(nclr), 1);
        check("done_a_out", 32'(a_v[0]), 0);
        check("done_busy", 32'(busy_v[0]), 0);

        // f stuck-at-1: mismatch on bit 2
        start_run(1, 1'b1, 1, 5, 1'b1, 5'd2, 2'b10, 2'b00);
        wait_done(1, 30);
        // f stuck-at-0: mismatch on bit 0, done 3 cycles after start
        start_run(2, 1'b1, 1, 3, 1'b1, 5'd0, 2'b00, 2'b10);
        wait_done(2, 30);

        // Abort mid-run at k=7, then rerun cleanly
        @(negedge Clock);
        start_run(0, 1'b0, 1, 0, 1'b0, 5'd0, 2'b00, 2'b00);
        repeat (8) @(negedge Clock);
        check("k7_a_out", 32'(a_v[0]), 32'(seq0[7]));
        check("k7_busy", 32'(busy_v[0]), 1);
        nReset = 1'b0;
        #1;
        check("abort_outs", 32'(outs(0)), 0);
        @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);
        start_run(0, 1'b1, 1, 18, 1'b0, 5'd0, 2'b00, 2'b00);
        wait_done(0, 30);

        // start held high through much of the run must not restart it
        @(negedge Clock);
        start_run(0, 1'b1, 10, 18, 1'b0, 5'd0, 2'b00, 2'b00);
        check("hold_busy", 32'(busy_v[0]), 1);
        wait_done(0, 30);

        // Rerun from DONE clears done and fault during CLEAR
        start_run(1, 1'b1, 1, 5, 1'b1, 5'd2, 2'b10, 2'b00);
        wait_done(1, 30);
        check("fault_before_rerun", 32'(fault_v[1]), 1);
        start_run(1, 1'b1, 1, 5, 1'b1, 5'd2, 2'b10, 2'b00);
        check("rerun_done_low", 32'(done_v[1]), 0);
        check("rerun_fault_clear", 32'(fault_v[1]), 0);
        check("rerun_dut_clr", 32'(clr_v[1]), 1);
        wait_done(1, 30);

        repeat (2) @(negedge Clock);
        check("sb_empty", 32'(sbq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
